// File: rtl/vdma_pkg.sv
// Shared types and constants for the video DMA write-side (S2MM) burst scheduler.
//   vdma_state_e : scheduler FSM states
//   BURST_INCR   : AXI4 INCR burst encoding
//   RESP_OKAY    : AXI4 OKAY response encoding
//   clog2()      : ceiling log2 for sizing counters and awsize
package vdma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StAddr,
    StData,
    StDrain
  } vdma_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vdma_outstanding_cnt.sv
// Saturating up/down counter of AXI write bursts whose AW has been accepted but whose B
// response has not yet arrived.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   inc_i   : AW handshake (one more burst in flight)
//   dec_i   : B handshake (one burst retired); ignored when the count is already zero
//   full_o  : count has reached MaxCnt
//   empty_o : no bursts in flight
module vdma_outstanding_cnt
  import vdma_pkg::*;
#(
  parameter int unsigned MaxCnt = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CntW = clog2(MaxCnt + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inc_eff, dec_eff;

  assign full_o  = (cnt_q == CntW'(MaxCnt));
  assign empty_o = (cnt_q == '0);

  // A stray B with nothing in flight must not wrap the count.
  assign inc_eff = inc_i & ~full_o;
  assign dec_eff = dec_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc_eff, dec_eff})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vdma_s2mm_burst_sched.sv
// S2MM burst scheduler: drains a first-word-fall-through FIFO into AXI4 INCR write bursts,
// walking addresses across lines, frames and a ring of FRAME_BUFFER frame buffers.
// Single clock domain (m_axi_s2mm_aclk), synchronous active-high reset (m_axi_areset).
//   start/stop        : begin continuous capture / halt after the current frame
//   fifo_*            : FIFO read side (count, head word, pop strobe)
//   m_axi_s2mm_aw*    : write address channel, one burst in flight ahead of its data
//   m_axi_s2mm_w*     : write data channel, data taken straight from the FIFO head
//   m_axi_s2mm_b*     : write response channel, always ready outside reset
//   busy, frame_done  : status; frame_done pulses once per completed frame
//   wr_buf, rd_buf    : buffer being written / last fully completed buffer
//   err               : sticky bad-response flag
// Build option: define VDMA_BRESP_ERR_EN to act on SLVERR/DECERR responses (set err, end
// capture after the current frame, withhold rd_buf for it); otherwise bresp is ignored.
module vdma_s2mm_burst_sched
  import vdma_pkg::*;
#(
  parameter int unsigned AXI_S2MM_ADDR_WIDTH = 32,
  parameter int unsigned IMAGE_WIDTH         = 192,
  parameter int unsigned IMAGE_HEIGHT        = 10,
  parameter int unsigned FRAME_BUFFER        = 1,
  parameter logic [AXI_S2MM_ADDR_WIDTH-1:0] AXI_S2MM_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int unsigned AXI_S2MM_BURST_LEN  = 16,
  parameter int unsigned AXI_S2MM_DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTSTANDING     = 4,
  parameter int unsigned FIFO_CNT_WIDTH      = 10
) (
  input  logic                               m_axi_s2mm_aclk,
  input  logic                               m_axi_areset,
  input  logic                               start,
  input  logic                               stop,
  input  logic [FIFO_CNT_WIDTH-1:0]          fifo_rd_count,
  input  logic [AXI_S2MM_DATA_WIDTH-1:0]     fifo_dout,
  output logic                               fifo_rd_en,
  output logic [AXI_S2MM_ADDR_WIDTH-1:0]     m_axi_s2mm_awaddr,
  output logic [7:0]                         m_axi_s2mm_awlen,
  output logic [2:0]                         m_axi_s2mm_awsize,
  output logic [1:0]                         m_axi_s2mm_awburst,
  output logic                               m_axi_s2mm_awvalid,
  input  logic                               m_axi_s2mm_awready,
  output logic [AXI_S2MM_DATA_WIDTH-1:0]     m_axi_s2mm_wdata,
  output logic [AXI_S2MM_DATA_WIDTH/8-1:0]   m_axi_s2mm_wstrb,
  output logic                               m_axi_s2mm_wlast,
  output logic                               m_axi_s2mm_wvalid,
  input  logic                               m_axi_s2mm_wready,
  input  logic [1:0]                         m_axi_s2mm_bresp,
  input  logic                               m_axi_s2mm_bvalid,
  output logic                               m_axi_s2mm_bready,
  output logic                               busy,
  output logic                               frame_done,
  output logic [2:0]                         wr_buf,
  output logic [2:0]                         rd_buf,
  output logic                               err
);

  localparam int unsigned BYTES            = AXI_S2MM_DATA_WIDTH / 8;
  localparam int unsigned BURSTS_PER_FRAME = IMAGE_WIDTH * IMAGE_HEIGHT / AXI_S2MM_BURST_LEN;
  localparam int unsigned BeatW            = clog2(AXI_S2MM_BURST_LEN);
  localparam int unsigned BurstW           = clog2(BURSTS_PER_FRAME + 1);
  localparam logic [AXI_S2MM_ADDR_WIDTH-1:0] BurstBytes =
      AXI_S2MM_ADDR_WIDTH'(AXI_S2MM_BURST_LEN * BYTES);
  localparam logic [FIFO_CNT_WIDTH-1:0] BurstWords = FIFO_CNT_WIDTH'(AXI_S2MM_BURST_LEN);
  localparam logic [BeatW-1:0]          LastBeat   = BeatW'(AXI_S2MM_BURST_LEN - 1);
  localparam logic [BurstW-1:0]         LastBurst  = BurstW'(BURSTS_PER_FRAME - 1);

  if ((IMAGE_WIDTH % AXI_S2MM_BURST_LEN) != 0) begin : g_chk_width
    $error("IMAGE_WIDTH must be a multiple of AXI_S2MM_BURST_LEN");
  end
  if ((AXI_S2MM_BURST_LEN < 2) || (AXI_S2MM_BURST_LEN > 256) ||
      ((AXI_S2MM_BURST_LEN & (AXI_S2MM_BURST_LEN - 1)) != 0)) begin : g_chk_len
    $error("AXI_S2MM_BURST_LEN must be a power of 2 in 2..256");
  end
  if ((FRAME_BUFFER < 1) || (FRAME_BUFFER > 8)) begin : g_chk_fb
    $error("FRAME_BUFFER must be in 1..8");
  end

  vdma_state_e                    state_q, state_d;
  logic [AXI_S2MM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BeatW-1:0]               beat_cnt_q, beat_cnt_d;
  logic [BurstW-1:0]              burst_cnt_q, burst_cnt_d;
  logic [2:0]                     wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, buf_next;
  logic                           stop_q, stop_d, halt_q, halt_d, err_q, err_d;
  logic                           awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                           frame_done_q, frame_done_d, bready_q;
  logic                           aw_hs, w_hs, b_hs, b_err, out_full, out_empty;

  assign aw_hs = awvalid_q & m_axi_s2mm_awready;
  assign w_hs  = wvalid_q & m_axi_s2mm_wready;
  assign b_hs  = m_axi_s2mm_bvalid & bready_q;

`ifdef VDMA_BRESP_ERR_EN
  // Only responses that retire a real burst count; strays are ignored like the count.
  assign b_err = b_hs & ~out_empty & (m_axi_s2mm_bresp != RESP_OKAY);
`else
  logic unused_bresp;
  assign unused_bresp = ^m_axi_s2mm_bresp;
  assign b_err        = 1'b0;
`endif

  vdma_outstanding_cnt #(
    .MaxCnt (MAX_OUTSTANDING)
  ) u_outstanding_cnt (
    .clk_i   (m_axi_s2mm_aclk),
    .rst_i   (m_axi_areset),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  assign buf_next = (wr_buf_q == 3'(FRAME_BUFFER - 1)) ? 3'd0 : wr_buf_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    wr_buf_d     = wr_buf_q;
    rd_buf_d     = rd_buf_q;
    frame_done_d = 1'b0;
    stop_d       = stop_q | (stop & (state_q != StIdle));
    halt_d       = halt_q | b_err;
    err_d        = err_q | b_err;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StWaitData;
      end
      StWaitData: begin
        // A whole burst must already sit in the FIFO so W never stalls on data.
        if ((fifo_rd_count >= BurstWords) && !out_full) state_d = StAddr;
      end
      StAddr: begin
        if (aw_hs) begin
          addr_d     = addr_q + BurstBytes;
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          if (beat_cnt_q == LastBeat) begin
            beat_cnt_d  = '0;
            burst_cnt_d = burst_cnt_q + BurstW'(1);
            state_d     = (burst_cnt_q == LastBurst) ? StDrain : StWaitData;
          end else begin
            beat_cnt_d = beat_cnt_q + BeatW'(1);
          end
        end
      end
      StDrain: begin
        if (out_empty) begin
          frame_done_d = 1'b1;
          if (!halt_q) rd_buf_d = wr_buf_q;
          wr_buf_d    = buf_next;
          burst_cnt_d = '0;
          // Buffers are contiguous, so addr_q already points at the next one unless we wrap.
          if (buf_next == 3'd0) addr_d = AXI_S2MM_TARGET_SLAVE_BASE_ADDR;
          if (stop_q || halt_q) begin
            state_d = StIdle;
            stop_d  = 1'b0;
            halt_d  = 1'b0;
          end else begin
            state_d = StWaitData;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    awvalid_d = (state_d == StAddr);
    wvalid_d  = (state_d == StData);
  end

  always_ff @(posedge m_axi_s2mm_aclk) begin
    if (m_axi_areset) begin
      state_q      <= StIdle;
      addr_q       <= AXI_S2MM_TARGET_SLAVE_BASE_ADDR;
      beat_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      wr_buf_q     <= '0;
      rd_buf_q     <= '0;
      stop_q       <= 1'b0;
      halt_q       <= 1'b0;
      err_q        <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      frame_done_q <= 1'b0;
      bready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      wr_buf_q     <= wr_buf_d;
      rd_buf_q     <= rd_buf_d;
      stop_q       <= stop_d;
      halt_q       <= halt_d;
      err_q        <= err_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      frame_done_q <= frame_done_d;
      bready_q     <= 1'b1;
    end
  end

  assign fifo_rd_en         = w_hs;
  assign m_axi_s2mm_awaddr  = addr_q;
  assign m_axi_s2mm_awlen   = 8'(AXI_S2MM_BURST_LEN - 1);
  assign m_axi_s2mm_awsize  = 3'(clog2(BYTES));
  assign m_axi_s2mm_awburst = BURST_INCR;
  assign m_axi_s2mm_awvalid = awvalid_q;
  assign m_axi_s2mm_wdata   = fifo_dout;
  assign m_axi_s2mm_wstrb   = '1;
  assign m_axi_s2mm_wlast   = wvalid_q & (beat_cnt_q == LastBeat);
  assign m_axi_s2mm_wvalid  = wvalid_q;
  assign m_axi_s2mm_bready  = bready_q;
  assign busy               = (state_q != StIdle);
  assign frame_done         = frame_done_q;
  assign wr_buf             = wr_buf_q;
  assign rd_buf             = rd_buf_q;
  assign err                = err_q;

endmodule

// File: tb/tb_vdma_s2mm_burst_sched.sv
// Scoreboard bench for vdma_s2mm_burst_sched (192x10 frames, 16-beat bursts, 3 buffers).
module tb_vdma_s2mm_burst_sched;

  localparam int FrameWords = 1920;
  localparam int FrameBursts = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [9:0]  fifo_rd_count;
  logic [31:0] fifo_dout;
  logic        fifo_rd_en;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready = 1'b1;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready = 1'b1;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;
  logic        busy, frame_done, err;
  logic [2:0]  wr_buf, rd_buf;

  always #5 clk = ~clk;

  vdma_s2mm_burst_sched #(
    .FRAME_BUFFER (3)
  ) dut (
    .m_axi_s2mm_aclk    (clk),
    .m_axi_areset       (rst),
    .start              (start),
    .stop               (stop),
    .fifo_rd_count      (fifo_rd_count),
    .fifo_dout          (fifo_dout),
    .fifo_rd_en         (fifo_rd_en),
    .m_axi_s2mm_awaddr  (awaddr),
    .m_axi_s2mm_awlen   (awlen),
    .m_axi_s2mm_awsize  (awsize),
    .m_axi_s2mm_awburst (awburst),
    .m_axi_s2mm_awvalid (awvalid),
    .m_axi_s2mm_awready (awready),
    .m_axi_s2mm_wdata   (wdata),
    .m_axi_s2mm_wstrb   (wstrb),
    .m_axi_s2mm_wlast   (wlast),
    .m_axi_s2mm_wvalid  (wvalid),
    .m_axi_s2mm_wready  (wready),
    .m_axi_s2mm_bresp   (bresp),
    .m_axi_s2mm_bvalid  (bvalid),
    .m_axi_s2mm_bready  (bready),
    .busy               (busy),
    .frame_done         (frame_done),
    .wr_buf             (wr_buf),
    .rd_buf             (rd_buf),
    .err                (err)
  );

  // FIFO model: 'supply' words written so far, 'head' words popped.
  int supply = 0, head = 0;
  bit pop_now = 1'b0;

  function automatic logic [31:0] word_of(input int k);
    return {16'hD47A, k[15:0]};
  endfunction

  assign fifo_rd_count = ((supply - head) > 1023) ? 10'd1023 : 10'(supply - head);
  assign fifo_dout     = word_of(head);

  logic [31:0] exp_aw[$];
  logic [32:0] exp_w[$];
  logic [2:0]  exp_rd[$];

  int n_checks = 0, n_fail = 0;
  int aw_seen = 0, fd_seen = 0, b_issued = 0, b_credit = 0, err_b_idx = -1;
  bit bp = 1'b0, err_inject = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // Monitor: samples on the falling edge, pops expectations on each handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    pop_now = 1'b0;
    if (!rst) begin
      if (awvalid && awready) begin
        aw_seen++;
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else check("awaddr", 64'(awaddr), 64'(exp_aw.pop_front()));
        check("awlen", 64'(awlen), 64'd15);
        check("awsize", 64'(awsize), 64'd2);
        check("awburst", 64'(awburst), 64'd1);
      end
      if (wvalid && wready) begin
        pop_now = 1'b1;
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin
          e = exp_w.pop_front();
          check("wdata", 64'(wdata), 64'(e[31:0]));
          check("wlast", 64'(wlast), 64'(e[32]));
        end
        check("fifo_rd_en", 64'(fifo_rd_en), 64'd1);
        check("wstrb", 64'(wstrb), 64'hF);
      end
      if (frame_done) begin
        fd_seen++;
        if (exp_rd.size() == 0) fail_now("frame_done_unexpected");
        else check("rd_buf", 64'(rd_buf), 64'(exp_rd.pop_front()));
      end
    end
  end

  // Responder: FIFO pop, ready backpressure and B responses, driven just after the edge.
  always @(posedge clk) begin
    #1;
    if (pop_now) head++;
    awready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    wready  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!rst && b_credit > 0 && aw_seen > b_issued) begin
      bvalid = 1'b1;
      bresp  = (err_inject && b_issued == err_b_idx) ? 2'b10 : 2'b00;
      b_issued++;
      b_credit--;
    end else begin
      bvalid = 1'b0;
      bresp  = 2'b00;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit is_stop);
    @(posedge clk); #2;
    if (is_stop) stop = 1'b1; else start = 1'b1;
    @(posedge clk); #2;
    stop  = 1'b0;
    start = 1'b0;
  endtask

  task automatic add_supply(input int n);
    for (int k = supply; k < supply + n; k++) exp_w.push_back({(k % 16) == 15, word_of(k)});
    supply += n;
  endtask

  task automatic plan_frame(input logic [31:0] base, input logic [2:0] rd);
    for (int i = 0; i < FrameBursts; i++) exp_aw.push_back(base + 32'(i * 64));
    exp_rd.push_back(rd);
  endtask

  task automatic wait_fd(input int target, input string name);
    int t;
    t = 0;
    while (fd_seen < target && t < 12000) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(fd_seen), 64'(target));
  endtask

  initial begin
    int t;
    cycles(3);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_bufs", 64'({wr_buf, rd_buf}), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    cycles(2);
    check("bready_after_rst", 64'(bready), 64'd1);

    // Frame 0 into buffer 0; 15 words are not enough for a burst.
    plan_frame(32'h4000_0000, 3'd0);
    add_supply(15);
    pulse(1'b0);
    cycles(20);
    check("busy_after_start", 64'(busy), 64'd1);
    check("no_aw_at_15", 64'(aw_seen), 64'd0);
    check("awvalid_at_15", 64'(awvalid), 64'd0);
    @(posedge clk); #2 add_supply(1);
    t = 0;
    while (!awvalid && t < 2) begin
      @(posedge clk); #2;
      t++;
    end
    check("awvalid_after_16", 64'(awvalid), 64'd1);

    // No B responses yet: only MAX_OUTSTANDING bursts may be issued.
    add_supply(FrameWords - 16);
    cycles(300);
    check("aw_stall_at_4", 64'(aw_seen), 64'd4);
    check("awvalid_stalled", 64'(awvalid), 64'd0);
    b_credit = 1;
    t = 0;
    while (aw_seen < 5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    cycles(100);
    check("aw_after_one_b", 64'(aw_seen), 64'd5);

    b_credit = 1 << 30;
    bp = 1'b1;
    wait_fd(1, "frame0_done");

    // Frames 1..3 rotate through buffers 1, 2, then back to 0; stop during frame 3.
    plan_frame(32'h4000_1E00, 3'd1);
    plan_frame(32'h4000_3C00, 3'd2);
    plan_frame(32'h4000_0000, 3'd0);
    add_supply(3 * FrameWords);
    wait_fd(2, "frame1_done");
    wait_fd(3, "frame2_done");
    pulse(1'b1);
    wait_fd(4, "frame3_done");
    cycles(3);
    check("idle_after_stop", 64'(busy), 64'd0);
    check("wr_buf_after_4", 64'(wr_buf), 64'd1);
    check("rd_buf_after_4", 64'(rd_buf), 64'd0);
    check("aw_total_4", 64'(aw_seen), 64'd480);

    // Fifth burst of the next frame returns SLVERR.
    err_b_idx  = b_issued + 4;
    err_inject = 1'b1;
`ifdef VDMA_BRESP_ERR_EN
    plan_frame(32'h4000_1E00, 3'd0);
`else
    plan_frame(32'h4000_1E00, 3'd1);
`endif
    add_supply(FrameWords);
    pulse(1'b0);
    wait_fd(5, "err_frame_done");
    cycles(2);
`ifdef VDMA_BRESP_ERR_EN
    check("err_set", 64'(err), 64'd1);
    check("idle_after_err", 64'(busy), 64'd0);
    check("wr_buf_after_err", 64'(wr_buf), 64'd2);
`else
    check("err_ignored", 64'(err), 64'd0);
    check("busy_continues", 64'(busy), 64'd1);
    plan_frame(32'h4000_3C00, 3'd2);
    add_supply(FrameWords);
    pulse(1'b1);
    wait_fd(6, "frame5_done");
    cycles(3);
    check("idle_after_stop2", 64'(busy), 64'd0);
    check("err_still_0", 64'(err), 64'd0);
`endif
    check("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
    check("w_queue_empty", 64'(exp_w.size()), 64'd0);
    check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
